// File: rtl/ram_sp_wf_arst_1024x16.sv
// ram_sp_wf_arst_1024x16: single-port write-first RAM with async active-low reset of the output register
module ram_sp_wf_arst_1024x16 #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] di,
  output logic [DATA_WIDTH-1:0] dout
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH] = '{default: '0};
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  assign dout_d = we ? di : mem[addr];
  assign dout = dout_q;
  always_ff @(posedge clk)
    if (rst && we) mem[addr] <= di;
  always_ff @(posedge clk or negedge rst)
    if (!rst) dout_q <= '0;
    else      dout_q <= dout_d;
endmodule

// File: tb/tb_ram_sp_wf_arst_1024x16.sv
// tb_ram_sp_wf_arst_1024x16: directed table, write/read passes and random soak against a reference model
module tb_ram_sp_wf_arst_1024x16;
  logic clk, rst, we;
  logic [9:0] addr;
  logic [15:0] di, dout;
  logic [15:0] model [1024];
  logic [15:0] wr [1024];
  logic [15:0] mdout;
  int errors = 0, checks = 0;
  typedef struct {
    logic        we;
    logic [9:0]  addr;
    logic [15:0] di;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl [12];

  ram_sp_wf_arst_1024x16 dut (
    .clk(clk), .rst(rst), .we(we), .addr(addr), .di(di), .dout(dout)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] exp);
    checks++;
    if (dout !== exp) begin
      errors++;
      $display("FAIL %s: dout=%h expected=%h", name, dout, exp);
    end
  endtask

  task automatic step(input logic w, input logic [9:0] a, input logic [15:0] d);
    we = w; addr = a; di = d;
    @(posedge clk);
    if (rst) begin
      mdout = w ? d : model[a];
      if (w) model[a] = d;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) model[i] = '0;
    mdout = '0;
    we = 0; addr = '0; di = '0;
    rst = 1;
    #1 rst = 0;
    #1 chk("por_reset", 16'h0000);
    rst = 1;
    // reset and memory retention
    step(1, 10'd5, 16'hBEEF);
    chk("write_beef", 16'hBEEF);
    #2 rst = 0;
    #1 chk("async_rst", 16'h0000);
    mdout = '0;
    step(0, 10'd5, 16'h0);
    chk("rst_hold", 16'h0000);
    rst = 1;
    step(0, 10'd5, 16'h0);
    chk("read_after_rst", 16'hBEEF);
    // write under reset is suppressed
    rst = 0;
    mdout = '0;
    step(1, 10'd20, 16'hAAAA);
    chk("wr_under_rst_dout", 16'h0000);
    rst = 1;
    step(0, 10'd20, 16'h0);
    chk("wr_under_rst_mem", 16'h0000);
    // directed table
    tbl[0]  = '{1'b1, 10'd10,   16'h1234, 16'h1234};
    tbl[1]  = '{1'b1, 10'd10,   16'h5678, 16'h5678};
    tbl[2]  = '{1'b0, 10'd10,   16'hFFFF, 16'h5678};
    tbl[3]  = '{1'b1, 10'd0,    16'h0001, 16'h0001};
    tbl[4]  = '{1'b1, 10'd1023, 16'hFFFF, 16'hFFFF};
    tbl[5]  = '{1'b0, 10'd0,    16'h0000, 16'h0001};
    tbl[6]  = '{1'b0, 10'd1023, 16'h0000, 16'hFFFF};
    tbl[7]  = '{1'b0, 10'd5,    16'h1111, 16'hBEEF};
    tbl[8]  = '{1'b0, 10'd7,    16'h2222, 16'h0000};
    tbl[9]  = '{1'b1, 10'd7,    16'hA5A5, 16'hA5A5};
    tbl[10] = '{1'b0, 10'd7,    16'h0000, 16'hA5A5};
    tbl[11] = '{1'b0, 10'd10,   16'h0000, 16'h5678};
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].we, tbl[i].addr, tbl[i].di);
      chk($sformatf("tbl[%0d]", i), tbl[i].exp);
    end
    // sequential write then read passes
    for (int i = 0; i < 1024; i++) begin
      wr[i] = 16'($urandom);
      step(1, 10'(i), wr[i]);
      chk($sformatf("seq_wr[%0d]", i), wr[i]);
    end
    for (int i = 0; i < 1024; i++) begin
      step(0, 10'(i), 16'($urandom));
      chk($sformatf("seq_rd[%0d]", i), wr[i]);
    end
    // random soak including mid-cycle reset pulses
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 9) != 0);
      if (!rst) begin
        #1 chk($sformatf("soak_arst[%0d]", i), 16'h0000);
        mdout = '0;
      end
      step(1'($urandom), 10'($urandom_range(0, 15) == 0 ? $urandom : $urandom_range(0, 31)), 16'($urandom));
      chk($sformatf("soak[%0d]", i), mdout);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
